// File: rtl/rtc_tick_sched.sv
// Tick scheduler for the PDP-8/I variable-clock pulse datapath.
// Produces fixed-width tick pulses at a programmable interval and keeps a sticky flag for IOT skip tests.
module rtc_tick_sched #(
  parameter int CLK_HZ       = 100000000,
  parameter int DEF_FREQ     = 120000,
  parameter int PULSE_CYCLES = 9,
  parameter int CNT_W        = 23
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [11:0]      cmd_count,
  input  logic             flag_clr,
  output logic             tick_p,
  output logic             tick_n,
  output logic             flag,
  output logic             busy,
  output logic [1:0]       state
);

  localparam logic [CNT_W-1:0] P_DEF = CNT_W'(CLK_HZ / DEF_FREQ - 1);
  localparam logic [CNT_W-1:0] P_MIN = CNT_W'(PULSE_CYCLES);
  localparam int               PCW   = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
  localparam logic [PCW-1:0]   PC_LAST = PCW'(PULSE_CYCLES - 1);

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_BURST = 2'b10;

  localparam logic [1:0] OP_STOP   = 2'b00;
  localparam logic [1:0] OP_RUN    = 2'b01;
  localparam logic [1:0] OP_BURST  = 2'b10;
  localparam logic [1:0] OP_SINGLE = 2'b11;

  logic [1:0]       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] period_q;
  logic [CNT_W-1:0] shadow_q;
  logic [12:0]      remain_q;
  logic [PCW-1:0]   pcnt_q;
  logic             tick_q;
  logic             flag_q;

  logic             cmd_fire;
  logic             counting;
  logic             wrap;
  logic             last_tick;
  logic [CNT_W-1:0] cfg_val;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    cmd_fire  = 1'b0;
    counting  = 1'b0;
    wrap      = 1'b0;
    last_tick = 1'b0;
    cfg_val   = cfg_period;
    if (cfg_period < P_MIN) cfg_val = P_MIN;
    cmd_fire  = cmd_valid && !tick_q;
    counting  = (state_q == ST_RUN) || (state_q == ST_BURST);
    // An accepted command restarts the sequence, so it suppresses a coincident wrap.
    wrap      = counting && (cnt_q == period_q) && !cmd_fire;
    last_tick = wrap && (state_q == ST_BURST) && (remain_q == 13'd1);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      remain_q <= '0;
    end else if (cmd_fire) begin
      cnt_q <= '0;
      case (cmd_op)
        OP_STOP: begin
          state_q  <= ST_IDLE;
          remain_q <= '0;
        end
        OP_RUN:    state_q <= ST_RUN;
        OP_BURST: begin
          state_q  <= ST_BURST;
          remain_q <= (cmd_count == 12'd0) ? 13'd4096 : {1'b0, cmd_count};
        end
        OP_SINGLE: begin
          state_q  <= ST_BURST;
          remain_q <= 13'd1;
        end
        default:   state_q <= ST_IDLE;
      endcase
    end else if (wrap) begin
      cnt_q <= '0;
      if (state_q == ST_BURST) remain_q <= remain_q - 13'd1;
      if (last_tick) state_q <= ST_IDLE;
    end else if (counting) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // New periods take effect only on a wrap (or at once when idle) so a running interval is never cut short.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= P_DEF;
      period_q <= P_DEF;
    end else begin
      if (cfg_we) shadow_q <= cfg_val;
      if (state_q == ST_IDLE) period_q <= cfg_we ? cfg_val : shadow_q;
      else if (wrap)          period_q <= shadow_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q <= 1'b0;
      pcnt_q <= '0;
      flag_q <= 1'b0;
    end else begin
      if (wrap) begin
        tick_q <= 1'b1;
        pcnt_q <= PC_LAST;
      end else if (tick_q) begin
        if (pcnt_q == '0) tick_q <= 1'b0;
        else              pcnt_q <= pcnt_q - 1'b1;
      end
      if (wrap)          flag_q <= 1'b1;
      else if (flag_clr) flag_q <= 1'b0;
    end
  end

  assign tick_p    = tick_q;
  assign tick_n    = ~tick_q;
  assign flag      = flag_q;
  assign cmd_ready = !tick_q;
  assign busy      = (state_q != ST_IDLE) || tick_q;
  assign state     = state_q;

endmodule

// File: tb/tb_rtc_tick_sched.sv
// Directed bench for rtc_tick_sched: expected tick-rise cycles are queued when commands are issued
// and checked by a monitor as each rise appears; pulse widths and control outputs are checked inline.
module tb_rtc_tick_sched;

  localparam int PULSE = 9;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_we;
  logic [22:0] cfg_period;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [11:0] cmd_count;
  logic        flag_clr;
  logic        tick_p;
  logic        tick_n;
  logic        flag;
  logic        busy;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int exp_q[$];
  bit skip_width = 1'b0;

  rtc_tick_sched dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_we     (cfg_we),
    .cfg_period (cfg_period),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_count  (cmd_count),
    .flag_clr   (flag_clr),
    .tick_p     (tick_p),
    .tick_n     (tick_n),
    .flag       (flag),
    .busy       (busy),
    .state      (state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Rise-time scoreboard and pulse-width monitor, sampled on the falling edge.
  logic prev_tp = 1'b0;
  int   rise_cyc = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_tp = 1'b0;
    end else begin
      if (tick_p && !prev_tp) begin
        int exp_v;
        exp_v = (exp_q.size() == 0) ? -1 : exp_q.pop_front();
        rise_cyc = cyc;
        checks++;
        assert (cyc === exp_v) else begin
          errors++;
          $error("FAIL rise_time: observed %0d expected %0d", cyc, exp_v);
        end
      end
      if (!tick_p && prev_tp && !skip_width) chk("pulse_width", cyc - rise_cyc, PULSE);
      prev_tp = tick_p;
    end
  end

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic set_period(input logic [22:0] p);
    @(negedge clk);
    cfg_we = 1'b1;
    cfg_period = p;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic drive_cmd(input logic [1:0] op, input logic [11:0] cnt, output int acc);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_count = cnt;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_ready_wait", cmd_ready, 1);
    acc = cyc + 1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int a;
    int n;
    rst_n = 1'b0; cfg_we = 1'b0; cfg_period = '0; cmd_valid = 1'b0;
    cmd_op = 2'b00; cmd_count = '0; flag_clr = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_tick_p", tick_p, 0);
    chk("rst_tick_n", tick_n, 1);
    chk("rst_flag", flag, 0);
    chk("rst_busy", busy, 0);
    chk("rst_state", state, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    wait_until(cyc + 2000);
    chk("idle_no_tick", exp_q.size(), 0);

    // Single at the default period of 832: rise 833 cycles after accept.
    drive_cmd(2'b11, 12'd0, a);
    exp_q.push_back(a + 833);
    wait_until(a + 833);
    chk("single_state_idle_at_rise", state, 0);
    chk("single_busy_at_rise", busy, 1);
    chk("single_flag_set", flag, 1);
    wait_until(a + 842);
    chk("single_busy_after_pulse", busy, 0);
    flag_clr = 1'b1;
    @(negedge clk);
    flag_clr = 1'b0;
    chk("flag_cleared", flag, 0);

    // Run at P=99 with flag clear/set race, then stop between pulses.
    set_period(23'd99);
    drive_cmd(2'b01, 12'd0, a);
    for (int k = 1; k <= 4; k++) exp_q.push_back(a + 100 * k);
    wait_until(a + 100);
    chk("run_flag_first_rise", flag, 1);
    chk("run_tick_n_complement", tick_n, 0);
    wait_until(a + 150);
    flag_clr = 1'b1;
    @(negedge clk);
    flag_clr = 1'b0;
    chk("run_flag_clr", flag, 0);
    wait_until(a + 199);
    flag_clr = 1'b1;
    @(negedge clk);
    flag_clr = 1'b0;
    chk("flag_set_wins", flag, 1);
    wait_until(a + 450);
    drive_cmd(2'b00, 12'd0, a);
    wait_until(a + 300);
    chk("stop_state", state, 0);
    chk("stop_busy", busy, 0);
    chk("run_all_ticks_seen", exp_q.size(), 0);

    // Period shrink mid-run: current interval completes, then clamped spacing of 10.
    drive_cmd(2'b01, 12'd0, a);
    exp_q.push_back(a + 100);
    exp_q.push_back(a + 110);
    exp_q.push_back(a + 120);
    exp_q.push_back(a + 130);
    wait_until(a + 50);
    cfg_we = 1'b1;
    cfg_period = 23'd3;
    @(negedge clk);
    cfg_we = 1'b0;
    wait_until(a + 132);
    chk("ready_low_in_pulse", cmd_ready, 0);
    cmd_valid = 1'b1;
    cmd_op = 2'b00;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("deferred_stop_accept_edge", cyc + 1, a + 140);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("deferred_stop_state", state, 0);
    wait_until(cyc + 200);
    chk("deferred_stop_no_more_ticks", exp_q.size(), 0);

    // Burst of 3 at P=99.
    set_period(23'd99);
    drive_cmd(2'b10, 12'd3, a);
    for (int k = 1; k <= 3; k++) exp_q.push_back(a + 100 * k);
    wait_until(a + 300);
    chk("burst3_state_at_last_rise", state, 0);
    chk("burst3_busy_at_last_rise", busy, 1);
    wait_until(a + 308);
    chk("burst3_busy_pulse_end", busy, 1);
    @(negedge clk);
    chk("burst3_busy_fall", busy, 0);
    wait_until(cyc + 200);
    chk("burst3_count", exp_q.size(), 0);

    // Burst count 0 means 4096; period written below the pulse width clamps to 9.
    set_period(23'd2);
    drive_cmd(2'b10, 12'd0, a);
    for (int k = 1; k <= 4096; k++) exp_q.push_back(a + 10 * k);
    wait_until(a + 40960);
    chk("burst4096_state_at_last_rise", state, 0);
    wait_until(a + 40969);
    chk("burst4096_busy_fall", busy, 0);
    wait_until(cyc + 50);
    chk("burst4096_count", exp_q.size(), 0);

    // Asynchronous reset in the middle of a pulse.
    drive_cmd(2'b01, 12'd0, a);
    exp_q.push_back(a + 10);
    wait_until(a + 12);
    chk("pre_reset_tick_p", tick_p, 1);
    skip_width = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_tick_p", tick_p, 0);
    chk("async_rst_tick_n", tick_n, 1);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_flag", flag, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    skip_width = 1'b0;
    chk("final_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
